// File: rtl/fetch_exec_ctrl_pkg.sv
// Shared types and counter widths for the RV32 multicycle fetch/execute sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT,
        FETCH_REQ,
        FETCH_WAIT,
        EXECUTE,
        MEM_WAIT,
        HALT,
        FAULT
    } ctrl_state_e;

    // BOOT_CYCLES and TIMEOUT must fit in these widths.
    localparam int BOOT_CNT_W = 16;
    localparam int TMO_CNT_W  = 16;

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Bus-wait watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module ctrl_timeout_cnt
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int W       = TMO_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Saturates at LAST so a stalled waiter keeps seeing o_expired.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            cnt <= '0;
        end else if (i_en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (cnt == LAST);

endmodule

// File: rtl/fetch_exec_ctrl.sv
// Multicycle RV32 sequencer: fetch handshake, execute dispatch, dmem wait, halt/resume and fault.
module fetch_exec_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_imem_ready,
    input  logic             i_imem_rvalid,
    input  logic             i_is_mem,
    input  logic             i_is_jump,
    input  logic             i_br_taken,
    input  logic             i_ebreak,
    input  logic             i_illegal,
    input  logic             i_dmem_done,
    input  logic             i_resume,
    output logic             o_imem_req,
    output logic             o_ir_we,
    output logic             o_dmem_req,
    output logic             o_rf_we_en,
    output logic             o_pc_en,
    output logic             o_pc_sel,
    output logic             o_halted,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_retired
);

    localparam int                      BOOT_LAST_I = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
    localparam logic [BOOT_CNT_W-1:0]   BOOT_LAST   = BOOT_CNT_W'(BOOT_LAST_I);

    ctrl_state_e           state;
    logic [BOOT_CNT_W-1:0] boot_cnt;
    logic [CNT_W-1:0]      retired;
    logic                  tmo_clr;
    logic                  tmo_en;
    logic                  tmo_expired;

    // The states just before each wait clear the watchdog, so every wait starts from zero.
    assign tmo_clr = (state == FETCH_REQ) || (state == EXECUTE);
    assign tmo_en  = (state == FETCH_WAIT) || (state == MEM_WAIT);

    ctrl_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .W       (TMO_CNT_W)
    ) u_tmo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (tmo_clr),
        .i_en      (tmo_en),
        .o_expired (tmo_expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= BOOT;
            boot_cnt <= '0;
            retired  <= '0;
        end else begin
            unique case (state)
                BOOT: begin
                    if (BOOT_CYCLES == 0 || boot_cnt == BOOT_LAST) state <= FETCH_REQ;
                    else                                          boot_cnt <= boot_cnt + 1'b1;
                end
                FETCH_REQ: begin
                    if (i_imem_ready) state <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    // A response on the expiring cycle still counts.
                    if (i_imem_rvalid)    state <= EXECUTE;
                    else if (tmo_expired) state <= FAULT;
                end
                EXECUTE: begin
                    if (i_illegal)      state <= FAULT;
                    else if (i_ebreak)  state <= HALT;
                    else if (i_is_mem)  state <= MEM_WAIT;
                    else begin
                        state   <= FETCH_REQ;
                        retired <= retired + 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (i_dmem_done) begin
                        state   <= FETCH_REQ;
                        retired <= retired + 1'b1;
                    end else if (tmo_expired) begin
                        state <= FAULT;
                    end
                end
                HALT: begin
                    if (i_resume) state <= FETCH_REQ;
                end
                FAULT: state <= FAULT;
                default: state <= FAULT;
            endcase
        end
    end

    // Gated by reset so a request in flight drops the moment reset is asserted.
    always_comb begin
        o_imem_req = 1'b0;
        o_ir_we    = 1'b0;
        o_dmem_req = 1'b0;
        o_rf_we_en = 1'b0;
        o_pc_en    = 1'b0;
        o_pc_sel   = 1'b0;
        o_halted   = 1'b0;
        o_fault    = 1'b0;
        if (i_rst_n) begin
            unique case (state)
                FETCH_REQ:  o_imem_req = 1'b1;
                FETCH_WAIT: o_ir_we = i_imem_rvalid;
                EXECUTE: begin
                    if (!i_illegal && !i_ebreak) begin
                        if (i_is_mem) begin
                            o_dmem_req = 1'b1;
                        end else begin
                            o_pc_en    = 1'b1;
                            o_pc_sel   = i_br_taken | i_is_jump;
                            o_rf_we_en = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    o_dmem_req = 1'b1;
                    o_pc_en    = i_dmem_done;
                    o_rf_we_en = i_dmem_done;
                end
                HALT: begin
                    o_halted = 1'b1;
                    o_pc_en  = i_resume;
                end
                FAULT:   o_fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_retired = retired;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Directed bench for fetch_exec_ctrl: boot, ALU/branch/jump/load retire, timeout, halt, illegal, reset mid-load.
module tb_fetch_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0, imem_rvalid = 1'b0, is_mem = 1'b0, is_jump = 1'b0;
    logic        br_taken = 1'b0, ebreak = 1'b0, illegal = 1'b0, dmem_done = 1'b0, resume = 1'b0;
    logic        imem_req, ir_we, dmem_req, rf_we_en, pc_en, pc_sel, halted, fault;
    logic [31:0] retired;
    logic [31:0] outs;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] O_NONE  = 32'h00;
    localparam logic [31:0] O_IMEM  = 32'h80;
    localparam logic [31:0] O_IRWE  = 32'h40;
    localparam logic [31:0] O_DMEM  = 32'h20;
    localparam logic [31:0] O_RFWE  = 32'h10;
    localparam logic [31:0] O_PCEN  = 32'h08;
    localparam logic [31:0] O_PCSEL = 32'h04;
    localparam logic [31:0] O_HALT  = 32'h02;
    localparam logic [31:0] O_FAULT = 32'h01;

    always #5 clk = ~clk;

    fetch_exec_ctrl #(.BOOT_CYCLES(4), .TIMEOUT(16), .CNT_W(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_imem_ready  (imem_ready),
        .i_imem_rvalid (imem_rvalid),
        .i_is_mem      (is_mem),
        .i_is_jump     (is_jump),
        .i_br_taken    (br_taken),
        .i_ebreak      (ebreak),
        .i_illegal     (illegal),
        .i_dmem_done   (dmem_done),
        .i_resume      (resume),
        .o_imem_req    (imem_req),
        .o_ir_we       (ir_we),
        .o_dmem_req    (dmem_req),
        .o_rf_we_en    (rf_we_en),
        .o_pc_en       (pc_en),
        .o_pc_sel      (pc_sel),
        .o_halted      (halted),
        .o_fault       (fault),
        .o_retired     (retired)
    );

    assign outs = {24'b0, imem_req, ir_we, dmem_req, rf_we_en, pc_en, pc_sel, halted, fault};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step after the edge into the next state.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    // From FETCH_REQ: handshake, one-cycle response, ends just inside EXECUTE.
    task automatic do_fetch();
        imem_ready = 1'b1;
        #1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        #1;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        int dcnt;

        // Reset and boot
        repeat (2) tick();
        chk("rst_outs", outs, O_NONE);
        chk("rst_retired", retired, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("boot_c%0d", c), outs, O_NONE);
            tick();
        end
        #1;
        chk("boot_first_req", outs, O_IMEM);

        // rvalid is ignored while requesting
        imem_rvalid = 1'b1;
        #1;
        tick();
        chk("freq_rvalid_ign", outs, O_IMEM);
        imem_rvalid = 1'b0;

        // ALU op, rvalid two cycles after ready
        imem_ready = 1'b1;
        #1;
        tick();
        imem_ready = 1'b0;
        #1;
        chk("alu_wait1", outs, O_NONE);
        tick();
        imem_rvalid = 1'b1;
        #1;
        chk("alu_irwe", outs, O_IRWE);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("alu_exec", outs, O_PCEN | O_RFWE);
        chk("alu_ret_before", retired, 32'd0);
        tick();
        chk("alu_ret_after", retired, 32'd1);
        chk("alu_back_req", outs, O_IMEM);

        // Taken branch
        do_fetch();
        br_taken = 1'b1;
        #1;
        chk("br_exec", outs, O_PCEN | O_PCSEL | O_RFWE);
        tick();
        br_taken = 1'b0;
        #1;
        chk("br_one_cycle", outs, O_IMEM);
        chk("br_ret", retired, 32'd2);

        // JAL
        do_fetch();
        is_jump = 1'b1;
        #1;
        chk("jal_exec", outs, O_PCEN | O_PCSEL | O_RFWE);
        tick();
        is_jump = 1'b0;
        chk("jal_ret", retired, 32'd3);

        // Load, done on the 5th MEM_WAIT cycle
        do_fetch();
        is_mem = 1'b1;
        dcnt = 0;
        #1;
        chk("ld_exec", outs, O_DMEM);
        if (dmem_req) dcnt++;
        tick();
        is_mem = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            dmem_done = (k == 5);
            #1;
            chk($sformatf("ld_wait%0d", k), outs, (k == 5) ? (O_DMEM | O_PCEN | O_RFWE) : O_DMEM);
            if (dmem_req) dcnt++;
            tick();
        end
        dmem_done = 1'b0;
        #1;
        chk("ld_req_cycles", dcnt, 32'd6);
        chk("ld_ret", retired, 32'd4);
        chk("ld_back_req", outs, O_IMEM);

        // EBREAK, 10 halted cycles, then resume
        do_fetch();
        ebreak = 1'b1;
        #1;
        chk("ebrk_exec", outs, O_NONE);
        tick();
        ebreak = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("halt%0d", k), outs, O_HALT);
            tick();
        end
        resume = 1'b1;
        #1;
        chk("resume", outs, O_HALT | O_PCEN);
        tick();
        resume = 1'b0;
        #1;
        chk("resume_req", outs, O_IMEM);
        chk("resume_ret", retired, 32'd4);

        // Fetch timeout: no rvalid for 16 wait cycles
        imem_ready = 1'b1;
        #1;
        tick();
        imem_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk($sformatf("tmo_wait%0d", k), outs, O_NONE);
            tick();
        end
        chk("tmo_fault", outs, O_FAULT);
        imem_ready = 1'b1;
        imem_rvalid = 1'b1;
        resume = 1'b1;
        repeat (3) tick();
        chk("tmo_sticky", outs, O_FAULT);
        chk("tmo_ret", retired, 32'd4);
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        resume = 1'b0;

        // rvalid on the 16th wait cycle beats the timeout
        do_reset();
        chk("rst2_req", outs, O_IMEM);
        chk("rst2_ret", retired, 32'd0);
        imem_ready = 1'b1;
        #1;
        tick();
        imem_ready = 1'b0;
        repeat (15) tick();
        imem_rvalid = 1'b1;
        #1;
        chk("tmo16_irwe", outs, O_IRWE);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("tmo16_exec", outs, O_PCEN | O_RFWE);
        tick();
        chk("tmo16_ret", retired, 32'd1);

        // Illegal outranks EBREAK and faults
        do_fetch();
        illegal = 1'b1;
        ebreak  = 1'b1;
        #1;
        chk("ill_exec", outs, O_NONE);
        tick();
        illegal = 1'b0;
        ebreak  = 1'b0;
        chk("ill_fault", outs, O_FAULT);
        chk("ill_ret", retired, 32'd1);

        // Reset in the middle of MEM_WAIT
        do_reset();
        do_fetch();
        is_mem = 1'b1;
        #1;
        tick();
        is_mem = 1'b0;
        tick();
        chk("rstmw_req", outs, O_DMEM);
        rst_n = 1'b0;
        dmem_done = 1'b1;
        #1;
        chk("rstmw_drop", outs, O_NONE);
        tick();
        dmem_done = 1'b0;
        chk("rstmw_next", outs, O_NONE);
        chk("rstmw_ret", retired, 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rstmw_reboot", outs, O_IMEM);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
